// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 receive path: receiver FSM state encoding,
// frame geometry, odd-parity helper, and the scan-code prefixes that the
// downstream scan-code interpreter keys on.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] SC_EXTEND = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;

  // Parity bit a device must send so that data plus parity has an odd
  // number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
// Two-flop synchronizer followed by a majority-free glitch filter and a
// falling-edge detector for one raw PS/2 line.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_line   raw asynchronous pin
//   o_level  filtered level, resets to 1
//   o_fall   one-cycle pulse on each 1->0 transition of o_level
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  all_low;
  logic                  all_high;

  // The level only moves once the whole history window agrees, so any
  // excursion shorter than FILTER_LEN samples is ignored.
  assign all_low  = (hist_q == '0);
  assign all_high = (&hist_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= 2'b11;
      hist_q  <= '1;
      o_level <= 1'b1;
      o_fall  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_line};
      hist_q <= {hist_q[FILTER_LEN-2:0], sync_q[1]};
      if (all_low) begin
        o_level <= 1'b0;
      end else if (all_high) begin
        o_level <= 1'b1;
      end
      // Registered alongside the level change so the pulse lines up with
      // the first cycle o_level reads 0.
      o_fall <= o_level & all_low;
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// ps2_receiver
// PS/2 device-to-host frame receiver. Conditions the raw clock/data pins,
// deserializes 11-bit frames (start, 8 data LSB first, odd parity, stop) and
// presents each good byte with a one-cycle strobe.
//
// Ports:
//   i_clk       system clock (50 MHz nominal)
//   i_rst_n     asynchronous active-low reset
//   i_ps2_clk   raw PS/2 clock pin
//   i_ps2_data  raw PS/2 data pin
//   o_data      last good byte, held between frames
//   o_valid     one-cycle pulse when o_data was just updated
//   o_err       one-cycle pulse on parity, stop-bit or timeout error
//   o_busy      high while a frame is in progress
//
// state  | meaning
// IDLE   | waiting for a start bit (fall with data low)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking parity and stop bit, then strobe valid or err
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_busy
);

  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DATA_BITS = PS2_FRAME_BITS - 3;

  ps2_state_t  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]  data_d;
  logic        valid_d, err_d, busy_d;

  logic [1:0]  data_sync_q;
  logic        data_s;
  logic        fclk;
  logic        fall;
  logic        timeout;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_line  (i_ps2_clk),
    .o_level (fclk),
    .o_fall  (fall)
  );

  // Data needs no filtering: it is only looked at in the fall cycle, long
  // after the device has settled it during the clock-high phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_sync_q <= 2'b11;
    end else begin
      data_sync_q <= {data_sync_q[0], i_ps2_data};
    end
  end

  assign data_s  = data_sync_q[1];
  assign timeout = (state_q != ST_IDLE) && (tcnt_q >= TW'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= 8'h00;
      cnt_q   <= 3'd0;
      par_q   <= 1'b0;
      tcnt_q  <= '0;
      o_data  <= 8'h00;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tcnt_q  <= tcnt_d;
      o_data  <= data_d;
      o_valid <= valid_d;
      o_err   <= err_d;
      o_busy  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    data_d  = o_data;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if ((state_q == ST_IDLE) || fall) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (fall && !data_s) begin
          shift_d = 8'h00;
          cnt_d   = 3'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d = {data_s, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          if ((par_q == odd_parity(shift_q)) && data_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A bit arriving in the same cycle as the timeout is still accepted.
    if (timeout && !fall) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      valid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver
// Directed bench for ps2_receiver. Bit period is scaled down to keep the run
// short; the timeout is scaled to match.
module tb_ps2_receiver;
  import ps2_pkg::*;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 400;
  localparam int HALF       = 40;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_err;
  logic       o_busy;

  int checks   = 0;
  int failures = 0;

  int valid_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  logic [7:0] got_q[$];

  ps2_receiver #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_err      (o_err),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (o_valid) begin
      valid_cnt++;
      got_q.push_back(o_data);
    end
    if (o_err) err_cnt++;
    if (o_valid && o_err) both_cnt++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One PS/2 bit: data settles while clock is high, then clock low, then high.
  // With glitch set, a 3-cycle low pulse is inserted in the high phase.
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cycles(HALF / 2);
      ps2_clk = 1'b0;
      wait_cycles(3);
      ps2_clk = 1'b1;
      wait_cycles(HALF / 2 - 3);
    end else begin
      wait_cycles(HALF);
    end
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stop, input int glitch_bit);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], (i == glitch_bit));
    ps2_data = 1'b1;
    wait_cycles(HALF);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(3);
    @(negedge clk);
    checks++;
    if (o_data !== 8'h00 || o_valid !== 1'b0 || o_err !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: data=%h valid=%b err=%b busy=%b, want 00 0 0 0",
               o_data, o_valid, o_err, o_busy);
    end
    rst_n = 1'b1;
    wait_cycles(20);
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || valid_cnt !== 0 || err_cnt !== 0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b valid_cnt=%0d err_cnt=%0d, want 0 0 0",
               o_busy, valid_cnt, err_cnt);
    end
  endtask

  task automatic test_single_frame();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h1D, 1'b1, 1'b1, -1);
    @(negedge clk);
    checks++;
    if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin
      failures++;
      $display("FAIL single_counts: valid=%0d err=%0d, want 1 0", valid_cnt - v0, err_cnt - e0);
    end
    checks++;
    if (o_data !== 8'h1D || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL single_data: data=%h busy=%b, want 1d 0", o_data, o_busy);
    end
  endtask

  task automatic test_back_to_back();
    int v0, idx;
    logic [7:0] exp_b[3];
    logic       exp_p[3];
    exp_b = '{SC_EXTEND, SC_BREAK, 8'h75};
    exp_p = '{1'b0, 1'b1, 1'b0};
    v0  = valid_cnt;
    idx = got_q.size();
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], exp_p[i], 1'b1, -1);
    @(negedge clk);
    checks++;
    if (valid_cnt - v0 !== 3) begin
      failures++;
      $display("FAIL b2b_count: got=%0d want=3", valid_cnt - v0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_q.size() <= idx + i) begin
        failures++;
        $display("FAIL b2b_byte%0d: missing, want %h", i, exp_b[i]);
      end else if (got_q[idx + i] !== exp_b[i]) begin
        failures++;
        $display("FAIL b2b_byte%0d: got=%h want=%h", i, got_q[idx + i], exp_b[i]);
      end
    end
  endtask

  task automatic test_bad_frames();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h1D, 1'b0, 1'b1, -1);
    @(negedge clk);
    checks++;
    if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0 || o_data !== 8'h75) begin
      failures++;
      $display("FAIL bad_parity: err=%0d valid=%0d data=%h, want 1 0 75",
               err_cnt - e0, valid_cnt - v0, o_data);
    end
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h1D, 1'b1, 1'b0, -1);
    @(negedge clk);
    checks++;
    if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0 || o_data !== 8'h75) begin
      failures++;
      $display("FAIL bad_stop: err=%0d valid=%0d data=%h, want 1 0 75",
               err_cnt - e0, valid_cnt - v0, o_data);
    end
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    wait_cycles(5);
    ps2_clk = 1'b0;
    wait_cycles(3);
    ps2_clk = 1'b1;
    wait_cycles(30);
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || err_cnt - e0 !== 0 || valid_cnt - v0 !== 0) begin
      failures++;
      $display("FAIL glitch_idle: busy=%b err=%0d valid=%0d, want 0 0 0",
               o_busy, err_cnt - e0, valid_cnt - v0);
    end
    send_frame(8'h23, 1'b0, 1'b1, 4);
    @(negedge clk);
    checks++;
    if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0 || o_data !== 8'h23) begin
      failures++;
      $display("FAIL glitch_frame: valid=%0d err=%0d data=%h, want 1 0 23",
               valid_cnt - v0, err_cnt - e0, o_data);
    end
  endtask

  task automatic test_timeout();
    int e0, v0, waited;
    logic [4:0] bits;
    bit seen;
    bits = 5'b01010;  // start bit then four data bits
    e0 = err_cnt; v0 = valid_cnt;
    for (int i = 0; i < 5; i++) send_bit(bits[i], 1'b0);
    // count from the last driven falling edge of the pin
    waited = HALF;
    seen = 1'b0;
    while (!seen && waited < 3 * TIMEOUT) begin
      @(negedge clk);
      if (o_err) seen = 1'b1;
      else waited++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL timeout_err: no err within %0d cycles", 3 * TIMEOUT);
    end else if (waited < TIMEOUT || waited > TIMEOUT + 30) begin
      failures++;
      $display("FAIL timeout_time: err after %0d cycles, want %0d..%0d",
               waited, TIMEOUT, TIMEOUT + 30);
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_err !== 1'b0 || err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
      failures++;
      $display("FAIL timeout_idle: busy=%b err=%b errs=%0d valids=%0d, want 0 0 1 0",
               o_busy, o_err, err_cnt - e0, valid_cnt - v0);
    end
    ps2_data = 1'b1;
    wait_cycles(10);
    v0 = valid_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    @(negedge clk);
    checks++;
    if (valid_cnt - v0 !== 1 || o_data !== 8'h1C) begin
      failures++;
      $display("FAIL timeout_recover: valid=%0d data=%h, want 1 1c", valid_cnt - v0, o_data);
    end
  endtask

  task automatic test_reset_midframe();
    int v0, e0;
    logic [5:0] bits;
    bits = {8'h1B, 1'b0};  // start + low five data bits of 0x1B
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 0; i < 6; i++) send_bit(bits[i], 1'b0);
    wait_cycles(5);
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL midframe_busy: busy=%b want 1", o_busy);
    end
    rst_n    = 1'b0;
    ps2_data = 1'b1;
    wait_cycles(4);
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_data !== 8'h00 || valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin
      failures++;
      $display("FAIL midframe_reset: busy=%b data=%h valid=%0d err=%0d, want 0 00 0 0",
               o_busy, o_data, valid_cnt - v0, err_cnt - e0);
    end
    rst_n = 1'b1;
    wait_cycles(20);
    send_frame(8'h1B, 1'b1, 1'b1, -1);
    @(negedge clk);
    checks++;
    if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0 || o_data !== 8'h1B) begin
      failures++;
      $display("FAIL midframe_after: valid=%0d err=%0d data=%h, want 1 0 1b",
               valid_cnt - v0, err_cnt - e0, o_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bad_frames();
    test_glitch();
    test_timeout();
    test_reset_midframe();
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL valid_err_overlap: cycles=%0d want 0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
